result_writeback: RTL and testbench

Result-side sink for the 4x4 systolic array wrapper. Snapshots the 16 signed 16-bit results `r_00`…`r_33` when the wrapper pulses `save_into_memory`. Writes them one per cycle into an internal 256-entry result memory at `base_addr + k`. Exposes a synchronous host read port, so results computed for each iteration are kept instead of being overwritten by the next iteration.

---
 rtl/result_writeback.sv | 163 ++++++++++++++++
 tb/tb_result_writeback.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// result_writeback: result-side sink for the 4x4 systolic array wrapper.
// On a capture strobe it snapshots the 16 results and base address. It then
// writes them one per cycle into a 2^ADDR_W-entry result memory at
// base+k, where the address wraps. A host reads the memory through a
// registered read port.
// Ports:
//   clk, rst              clock, async active-low reset
//   save_into_memory      capture strobe (accepted only when idle)
//   base_addr             destination base for the captured frame
//   r_00 .. r_33          result matrix, row-major (k = 4*i + j)
//   rd_en, rd_addr        host read request / address
//   rd_data               registered read data (1-cycle latency, read-before-write)
//   busy                  high while a frame is being written
//   wb_done               one-cycle pulse after a frame's last write
//   overflow              sticky: strobe arrived while busy
//   frames_written        completed-frame count, wraps
module result_writeback #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     save_into_memory,
    input  logic        [ADDR_W-1:0] base_addr,
    input  logic signed [DATA_W-1:0] r_00,
    input  logic signed [DATA_W-1:0] r_01,
    input  logic signed [DATA_W-1:0] r_02,
    input  logic signed [DATA_W-1:0] r_03,
    input  logic signed [DATA_W-1:0] r_10,
    input  logic signed [DATA_W-1:0] r_11,
    input  logic signed [DATA_W-1:0] r_12,
    input  logic signed [DATA_W-1:0] r_13,
    input  logic signed [DATA_W-1:0] r_20,
    input  logic signed [DATA_W-1:0] r_21,
    input  logic signed [DATA_W-1:0] r_22,
    input  logic signed [DATA_W-1:0] r_23,
    input  logic signed [DATA_W-1:0] r_30,
    input  logic signed [DATA_W-1:0] r_31,
    input  logic signed [DATA_W-1:0] r_32,
    input  logic signed [DATA_W-1:0] r_33,
    input  logic                     rd_en,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     wb_done,
    output logic                     overflow,
    output logic        [7:0]        frames_written
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [ADDR_W-1:0]         base_q;
    logic [DATA_W-1:0]         buf_q [NWORDS];
    logic [DATA_W-1:0]         mem   [DEPTH];
    logic [DATA_W-1:0]         r_in  [NWORDS];

    logic                      capture_c;
    logic                      wr_en_c;
    logic                      last_c;
    logic [ADDR_W-1:0]         wr_addr_d;
    logic [IDX_W-1:0]          idx_d;

    // Row-major flattening of the result matrix
    assign r_in[0]  = r_00;
    assign r_in[1]  = r_01;
    assign r_in[2]  = r_02;
    assign r_in[3]  = r_03;
    assign r_in[4]  = r_10;
    assign r_in[5]  = r_11;
    assign r_in[6]  = r_12;
    assign r_in[7]  = r_13;
    assign r_in[8]  = r_20;
    assign r_in[9]  = r_21;
    assign r_in[10] = r_22;
    assign r_in[11] = r_23;
    assign r_in[12] = r_30;
    assign r_in[13] = r_31;
    assign r_in[14] = r_32;
    assign r_in[15] = r_33;

    // Strobes are only accepted from IDLE; in WRITE they only flag overflow
    assign capture_c = (state_q == IDLE) && save_into_memory;
    assign wr_en_c   = (state_q == WRITE);
    assign last_c    = (idx_q == IDX_W'(NWORDS - 1));
    assign wr_addr_d = base_q + ADDR_W'(idx_q);
    assign idx_d     = idx_q + IDX_W'(1);

    // Control FSM with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            base_q         <= '0;
            busy           <= 1'b0;
            wb_done        <= 1'b0;
            overflow       <= 1'b0;
            frames_written <= '0;
        end else begin
            wb_done <= 1'b0;
            if (save_into_memory && (state_q == WRITE)) begin
                overflow <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (save_into_memory) begin
                        base_q  <= base_addr;
                        idx_q   <= '0;
                        state_q <= WRITE;
                        busy    <= 1'b1;
                    end
                end
                WRITE: begin
                    idx_q <= idx_d;
                    if (last_c) begin
                        state_q        <= IDLE;
                        busy           <= 1'b0;
                        wb_done        <= 1'b1;
                        frames_written <= frames_written + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot buffer isolates the frame from later input changes
    always_ff @(posedge clk) begin
        if (capture_c) begin
            for (int k = 0; k < NWORDS; k++) begin
                buf_q[k] <= r_in[k];
            end
        end
    end

    // Result memory write, one word per WRITE cycle
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_d] <= buf_q[idx_q];
        end
    end

    // Registered read port; nonblocking write gives read-before-write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: table-driven read checks, hand
// sequences for overflow / collision / mid-frame reset, randomized frames
// against a flat memory model.
module tb_result_writeback;

    logic               clk = 1'b0;
    logic               rst;
    logic               save_into_memory;
    logic        [7:0]  base_addr;
    logic signed [15:0] r [16];
    logic               rd_en;
    logic        [7:0]  rd_addr;
    logic signed [15:0] rd_data;
    logic               busy;
    logic               wb_done;
    logic               overflow;
    logic        [7:0]  frames_written;

    int checks   = 0;
    int failures = 0;

    // Reference model: what each address should hold, and the frame count
    int mem_m [256];
    bit val_m [256];
    int frames_m = 0;

    typedef struct {
        logic [7:0] addr;
        int         exp;
    } rvec_t;

    always #5 clk = ~clk;

    result_writeback dut (
        .clk(clk), .rst(rst), .save_into_memory(save_into_memory),
        .base_addr(base_addr),
        .r_00(r[0]),  .r_01(r[1]),  .r_02(r[2]),  .r_03(r[3]),
        .r_10(r[4]),  .r_11(r[5]),  .r_12(r[6]),  .r_13(r[7]),
        .r_20(r[8]),  .r_21(r[9]),  .r_22(r[10]), .r_23(r[11]),
        .r_30(r[12]), .r_31(r[13]), .r_32(r[14]), .r_33(r[15]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .wb_done(wb_done), .overflow(overflow),
        .frames_written(frames_written)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] b, input int v [16], input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] a;
            a = b + 8'(k);
            mem_m[a] = int'($signed(16'(v[k])));
            val_m[a] = 1'b1;
        end
    endfunction

    // Full frame: strobe, optionally scramble inputs after capture, count busy/wb_done
    task automatic do_frame(input logic [7:0] b, input int v [16], input bit scramble, input string nm);
        int bc;
        int wc;
        base_addr = b;
        for (int k = 0; k < 16; k++) r[k] = 16'(v[k]);
        save_into_memory = 1'b1;
        @(negedge clk);
        save_into_memory = 1'b0;
        if (scramble) begin
            for (int k = 0; k < 16; k++) r[k] = 16'h7FFF;
            base_addr = 8'h40;
        end
        bc = 0;
        wc = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) bc++;
            if (wb_done) wc++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, bc, 16);
        chk({nm, "_wb_done_pulses"}, wc, 1);
        model_frame(b, v, 16);
        frames_m = (frames_m + 1) % 256;
        chk({nm, "_frames_written"}, int'(frames_written), frames_m);
    endtask

    task automatic rd_chk(input logic [7:0] a, input int exp, input string nm);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        rd_addr = ~a;
        chk(nm, int'(rd_data), exp);
    endtask

    task automatic rand_vals(output int v [16]);
        for (int k = 0; k < 16; k++) v[k] = int'($signed(16'($urandom)));
    endtask

    initial begin
        rvec_t tbl [10];
        int    v [16];
        int    va [16];
        int    vb [16];
        int    vc [16];
        int    vn [16];
        int    ov_lo;
        int    bc;
        int    wc;
        int    frames0;
        int    old43;

        // Expected read values, computed by hand: basic frame r_ij = 16i+j-40
        // at 0x10, wrap frame r_ij = k+1 at 0xF8
        tbl[0] = '{8'h10, -40};
        tbl[1] = '{8'h13, -37};
        tbl[2] = '{8'h14, -24};
        tbl[3] = '{8'h1A, -6};
        tbl[4] = '{8'h1F, 11};
        tbl[5] = '{8'hF8, 1};
        tbl[6] = '{8'hFF, 8};
        tbl[7] = '{8'h00, 9};
        tbl[8] = '{8'h07, 16};
        tbl[9] = '{8'h1C, 8};

        for (int a = 0; a < 256; a++) begin
            mem_m[a] = 0;
            val_m[a] = 1'b0;
        end

        rst = 1'b0;
        save_into_memory = 1'b0;
        base_addr = '0;
        rd_en = 1'b0;
        rd_addr = '0;
        for (int k = 0; k < 16; k++) r[k] = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wb_done", int'(wb_done), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_frames", int'(frames_written), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rst = 1'b1;
        @(negedge clk);

        // Prefill regions that later tests must see untouched or overwritten
        rand_vals(v);
        do_frame(8'h40, v, 1'b0, "prefill40");
        rand_vals(v);
        do_frame(8'h60, v, 1'b0, "prefill60");

        // Basic frame with snapshot isolation (inputs scrambled after capture)
        for (int k = 0; k < 16; k++) v[k] = 16 * (k / 4) + (k % 4) - 40;
        do_frame(8'h10, v, 1'b1, "basic");

        // Wrap-around frame
        for (int k = 0; k < 16; k++) v[k] = k + 1;
        do_frame(8'hF8, v, 1'b0, "wrap");

        for (int i = 0; i < 10; i++) begin
            rd_chk(tbl[i].addr, tbl[i].exp, $sformatf("table_rd_%02h", tbl[i].addr));
        end
        repeat (2) @(negedge clk);
        chk("rd_hold", int'(rd_data), tbl[9].exp);

        // 0x40 region must still hold the prefill, not 0x7FFF
        for (int k = 0; k < 16; k++) begin
            rd_chk(8'h40 + 8'(k), mem_m[8'h40 + 8'(k)], $sformatf("isolation_rd_%0d", k));
        end

        // Read-before-write collision at base+3 (write of k=3 lands on E4)
        rand_vals(vn);
        vn[3] = int'($signed(16'(mem_m[8'h43] ^ 16'h5A5A)));
        old43 = mem_m[8'h43];
        base_addr = 8'h40;
        for (int k = 0; k < 16; k++) r[k] = 16'(vn[k]);
        for (int c = 0; c < 20; c++) begin
            save_into_memory = (c == 0);
            rd_en   = (c == 4) || (c == 5);
            rd_addr = 8'h43;
            @(negedge clk);
            if (c == 4) chk("collision_old", int'(rd_data), old43);
            if (c == 5) chk("collision_new", int'(rd_data), vn[3]);
        end
        rd_en = 1'b0;
        model_frame(8'h40, vn, 16);
        frames_m = (frames_m + 1) % 256;
        chk("collision_frames", int'(frames_written), frames_m);

        // Overflow: strobes at E0, E5, E16 (ignored), E17 (accepted)
        rand_vals(va);
        rand_vals(vb);
        rand_vals(vc);
        frames0 = frames_m;
        ov_lo = 0;
        for (int c = 0; c < 38; c++) begin
            save_into_memory = (c == 0) || (c == 5) || (c == 16) || (c == 17);
            if (c < 5) begin
                base_addr = 8'h20;
                for (int k = 0; k < 16; k++) r[k] = 16'(va[k]);
            end else if (c == 16) begin
                base_addr = 8'h50;
                for (int k = 0; k < 16; k++) r[k] = 16'(vc[k]);
            end else begin
                base_addr = 8'h30;
                for (int k = 0; k < 16; k++) r[k] = 16'(vb[k]);
            end
            @(negedge clk);
            if (c == 4) chk("ovf_before", int'(overflow), 0);
            if (c >= 5 && !overflow) ov_lo++;
            if (c == 15) chk("ovf_busy_e15", int'(busy), 1);
            if (c == 16) begin
                chk("ovf_busy_e16", int'(busy), 0);
                chk("ovf_frames_e16", int'(frames_written), (frames0 + 1) % 256);
            end
            if (c == 17) chk("ovf_busy_e17", int'(busy), 1);
            if (c == 32) chk("ovf_frames_e32", int'(frames_written), (frames0 + 1) % 256);
            if (c == 33) begin
                chk("ovf_wb_done_e33", int'(wb_done), 1);
                chk("ovf_frames_e33", int'(frames_written), (frames0 + 2) % 256);
            end
        end
        save_into_memory = 1'b0;
        chk("ovf_sticky", ov_lo, 0);
        model_frame(8'h20, va, 16);
        model_frame(8'h30, vb, 16);
        frames_m = (frames0 + 2) % 256;
        rd_chk(8'h20, mem_m[8'h20], "ovf_rd_20");
        rd_chk(8'h2F, mem_m[8'h2F], "ovf_rd_2F");
        rd_chk(8'h30, mem_m[8'h30], "ovf_rd_30");
        rd_chk(8'h3F, mem_m[8'h3F], "ovf_rd_3F");

        // Reset mid-frame: k=0..7 land at E1..E8, then reset between E8 and E9
        rand_vals(vn);
        base_addr = 8'h60;
        for (int k = 0; k < 16; k++) r[k] = 16'(vn[k]);
        save_into_memory = 1'b1;
        @(negedge clk);
        save_into_memory = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_wb_done", int'(wb_done), 0);
        chk("rstmid_overflow", int'(overflow), 0);
        chk("rstmid_frames", int'(frames_written), 0);
        chk("rstmid_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst = 1'b1;
        bc = 0;
        wc = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) bc++;
            if (wb_done) wc++;
            @(negedge clk);
        end
        chk("rstmid_no_busy", bc, 0);
        chk("rstmid_no_wb_done", wc, 0);
        model_frame(8'h60, vn, 8);
        frames_m = 0;
        rand_vals(v);
        do_frame(8'h80, v, 1'b0, "after_reset");
        for (int k = 0; k < 16; k++) begin
            rd_chk(8'h60 + 8'(k), mem_m[8'h60 + 8'(k)], $sformatf("rstmid_rd_%0d", k));
        end

        // Randomized frames and reads against the model
        for (int f = 0; f < 6; f++) begin
            rand_vals(v);
            do_frame(8'($urandom_range(0, 255)), v, 1'b0, $sformatf("rand_frame%0d", f));
        end
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 255));
            while (!val_m[a]) a = a + 8'd1;
            rd_chk(a, mem_m[a], $sformatf("rand_rd_%02h", a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
